// File: rtl/fib_codec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fib_codec_pkg
// Description : Widths, limits and FSM state type shared by the Fibonacci
//               (Zeckendorf) encoder and decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package fib_codec_pkg;

    localparam int FIB_W    = 32;
    localparam int BIN_W    = 16;
    localparam int ACC_W    = 24;
    localparam int IDX_W    = $clog2(FIB_W);
    localparam int CONV_LAT = 33;

    localparam logic [BIN_W-1:0] BIN_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fibonacci_binary_if.sv
`default_nettype none
// ============================================================================
// Module      : fibonacci_binary_if
// Description : Start/result bundle between a requester and the Zeckendorf
//               decoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface fibonacci_binary_if;
    import fib_codec_pkg::*;

    logic [FIB_W-1:0] fibonacci_standard;
    logic             begin_f_b;
    logic             busy;
    logic             convert_done;
    logic [BIN_W-1:0] binary_out;
    logic             err_noncanonical;
    logic             err_overflow;

    modport master (
        output fibonacci_standard, begin_f_b,
        input  busy, convert_done, binary_out, err_noncanonical, err_overflow
    );

    modport slave (
        input  fibonacci_standard, begin_f_b,
        output busy, convert_done, binary_out, err_noncanonical, err_overflow
    );

endinterface
`default_nettype wire

// File: rtl/fib_weight_seq.sv
`default_nettype none
// ============================================================================
// Module      : fib_weight_seq
// Description : Two-register Fibonacci generator producing the weight of the
//               current digit; clear loads (1,2), step advances one digit.
// Revision    : 1.0 - initial release
// ============================================================================
module fib_weight_seq
    import fib_codec_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clear,
    input  wire logic             step,
    output logic      [ACC_W-1:0] weight
);

    logic [ACC_W-1:0] r_w;
    logic [ACC_W-1:0] r_wn;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_w  <= '0;
            r_wn <= '0;
        end else if (clear) begin
            r_w  <= ACC_W'(1);
            r_wn <= ACC_W'(2);
        end else if (step) begin
            r_w  <= r_wn;
            r_wn <= r_w + r_wn;
        end
    end

    assign weight = r_w;

endmodule
`default_nettype wire

// File: rtl/fibonacci_binary.sv
`default_nettype none
// ============================================================================
// Module      : fibonacci_binary
// Description : Serial Zeckendorf-to-binary decoder, one digit per clock LSB
//               first, with canonical-form and range checking.
// Revision    : 1.0 - initial release
// ============================================================================
module fibonacci_binary
    import fib_codec_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst,
    fibonacci_binary_if.slave  bus
);

    state_t           r_state;
    logic [FIB_W-1:0] r_shreg;
    logic [ACC_W-1:0] r_acc;
    logic [IDX_W-1:0] r_idx;
    logic             r_prev;
    logic             r_noncanon;
    logic             r_busy;
    logic             r_done;
    logic [BIN_W-1:0] r_bin;
    logic             r_err_nc;
    logic             r_err_ov;

    logic             w_clear;
    logic             w_step;
    logic             w_digit;
    logic             w_ovf;
    logic [ACC_W-1:0] w_weight;

    always_comb begin
        w_clear = (r_state == IDLE) && bus.begin_f_b;
        w_step  = (r_state == RUN);
        w_digit = r_shreg[0];
        w_ovf   = r_acc > {{(ACC_W-BIN_W){1'b0}}, BIN_MAX};
    end

    fib_weight_seq u_weight (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_clear),
        .step   (w_step),
        .weight (w_weight)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_acc      <= '0;
            r_idx      <= '0;
            r_prev     <= 1'b0;
            r_noncanon <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bin      <= '0;
            r_err_nc   <= 1'b0;
            r_err_ov   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.begin_f_b) begin
                        r_shreg    <= bus.fibonacci_standard;
                        r_acc      <= '0;
                        r_idx      <= '0;
                        r_prev     <= 1'b0;
                        r_noncanon <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    if (w_digit) begin
                        r_acc <= r_acc + w_weight;
                    end
                    // Two consecutive 1 digits break Zeckendorf form
                    if (w_digit && r_prev) begin
                        r_noncanon <= 1'b1;
                    end
                    r_prev  <= w_digit;
                    r_shreg <= {1'b0, r_shreg[FIB_W-1:1]};
                    r_idx   <= r_idx + IDX_W'(1);
                    if (r_idx == IDX_W'(FIB_W-1)) begin
                        r_state <= FIN;
                    end
                end
                FIN: begin
                    r_err_ov <= w_ovf;
                    r_bin    <= w_ovf ? BIN_MAX : r_acc[BIN_W-1:0];
                    r_err_nc <= r_noncanon;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy             = r_busy;
    assign bus.convert_done     = r_done;
    assign bus.binary_out       = r_bin;
    assign bus.err_noncanonical = r_err_nc;
    assign bus.err_overflow     = r_err_ov;

endmodule
`default_nettype wire

// File: tb/tb_fibonacci_binary.sv
`default_nettype none
// ============================================================================
// Module      : tb_fibonacci_binary
// Description : Self-checking bench for the Zeckendorf decoder against a
//               weighted-sum reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fibonacci_binary;
    import fib_codec_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    fibonacci_binary_if bus ();

    fibonacci_binary dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] dir_word [7] = '{32'h0, 32'h004A9114, 32'h00505204, 32'h3,
                                  32'h4, 32'h00800000, 32'h00400001};
    logic [15:0] dir_bin  [7] = '{16'd0, 16'd63535, 16'hFFFF, 16'd3,
                                  16'd3, 16'hFFFF, 16'd46369};
    logic        dir_nc   [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        dir_ov   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reference: digit i weighs F(i+2), F(1)=F(2)=1
    function automatic longint unsigned zeck_value(input logic [31:0] w);
        longint unsigned f [36];
        longint unsigned s = 0;
        f[0] = 0; f[1] = 1; f[2] = 1;
        for (int n = 3; n < 36; n++) f[n] = f[n-1] + f[n-2];
        for (int i = 0; i < 32; i++) if (w[i]) s += f[i+2];
        return s;
    endfunction

    // Drives one start and waits (bounded) for the done pulse; no checking here
    task automatic convert(input logic [31:0] word, output int lat,
                           output logic [15:0] b, output logic nc, output logic ov,
                           output logic busy_ok, output logic busy_at_done);
        bus.fibonacci_standard = word;
        bus.begin_f_b          = 1'b1;
        @(posedge clk); #1;
        bus.begin_f_b          = 1'b0;
        bus.fibonacci_standard = $urandom;
        lat     = 0;
        busy_ok = 1'b1;
        while (!bus.convert_done && lat < 60) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        b            = bus.binary_out;
        nc           = bus.err_noncanonical;
        ov           = bus.err_overflow;
        busy_at_done = bus.busy;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.begin_f_b = 1'b0;
        bus.fibonacci_standard = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
        checks++; if (bus.convert_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", bus.convert_done); end
        checks++; if (bus.binary_out !== 16'h0) begin failures++; $display("FAIL reset_bin got=%h exp=0000", bus.binary_out); end
        checks++; if (bus.err_noncanonical !== 1'b0 || bus.err_overflow !== 1'b0) begin
            failures++; $display("FAIL reset_errs got=%b%b exp=00", bus.err_noncanonical, bus.err_overflow);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        int lat; logic [15:0] b; logic nc, ov, bok, bdone;
        for (int i = 0; i < 7; i++) begin
            convert(dir_word[i], lat, b, nc, ov, bok, bdone);
            checks++; if (lat != CONV_LAT) begin failures++; $display("FAIL dir_latency word=%h got=%0d exp=%0d", dir_word[i], lat, CONV_LAT); end
            checks++; if (b !== dir_bin[i]) begin failures++; $display("FAIL dir_bin word=%h got=%0d exp=%0d", dir_word[i], b, dir_bin[i]); end
            checks++; if (nc !== dir_nc[i]) begin failures++; $display("FAIL dir_noncanon word=%h got=%b exp=%b", dir_word[i], nc, dir_nc[i]); end
            checks++; if (ov !== dir_ov[i]) begin failures++; $display("FAIL dir_overflow word=%h got=%b exp=%b", dir_word[i], ov, dir_ov[i]); end
            checks++; if (bok !== 1'b1 || bdone !== 1'b0) begin
                failures++; $display("FAIL dir_busy word=%h busy_during=%b busy_at_done=%b exp=1/0", dir_word[i], bok, bdone);
            end
            @(posedge clk); #1;
            checks++; if (bus.convert_done !== 1'b0 || bus.binary_out !== dir_bin[i]) begin
                failures++; $display("FAIL dir_hold word=%h done=%b bin=%0d exp done=0 bin=%0d", dir_word[i], bus.convert_done, bus.binary_out, dir_bin[i]);
            end
        end
    endtask

    task automatic test_random();
        int lat; logic [15:0] b; logic nc, ov, bok, bdone;
        logic [31:0] w; longint unsigned s; logic [15:0] eb;
        for (int i = 0; i < 24; i++) begin
            w = $urandom;
            case ($urandom_range(0, 2))
                0: w = w & ~(w << 1);
                1: w = (w >> $urandom_range(8, 12)) & ~((w >> $urandom_range(8, 12)) << 1);
                default: w = w >> $urandom_range(0, 16);
            endcase
            s  = zeck_value(w);
            eb = (s > 65535) ? 16'hFFFF : s[15:0];
            convert(w, lat, b, nc, ov, bok, bdone);
            checks++; if (lat != CONV_LAT) begin failures++; $display("FAIL rnd_latency word=%h got=%0d exp=%0d", w, lat, CONV_LAT); end
            checks++; if (b !== eb || nc !== |(w & (w >> 1)) || ov !== (s > 65535)) begin
                failures++; $display("FAIL rnd_result word=%h got=%0d/%b/%b exp=%0d/%b/%b", w, b, nc, ov, eb, |(w & (w >> 1)), (s > 65535));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w; logic [15:0] eb;
        int cyc = 0, last = 0, pulses = 0;
        w  = $urandom_range(1, 32'h3FFFFF);
        w  = w & ~(w << 1);
        eb = zeck_value(w) > 65535 ? 16'hFFFF : 16'(zeck_value(w));
        bus.fibonacci_standard = w;
        bus.begin_f_b = 1'b1;
        while (pulses < 4 && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.convert_done) begin
                checks++; if ((cyc - last) != CONV_LAT + 1) begin
                    failures++; $display("FAIL b2b_interval pulse=%0d got=%0d exp=%0d", pulses, cyc - last, CONV_LAT + 1);
                end
                checks++; if (bus.binary_out !== eb) begin failures++; $display("FAIL b2b_bin got=%0d exp=%0d", bus.binary_out, eb); end
                last = cyc;
                pulses++;
            end
        end
        bus.begin_f_b = 1'b0;
        checks++; if (pulses != 4) begin failures++; $display("FAIL b2b_pulses got=%0d exp=4", pulses); end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_busy();
        logic [31:0] a, b; logic [15:0] ea;
        int lat = 0, extra = 0;
        a  = 32'h00012345 & ~(32'h00012345 << 1);
        b  = 32'h00000001;
        ea = 16'(zeck_value(a));
        bus.fibonacci_standard = a;
        bus.begin_f_b = 1'b1;
        @(posedge clk); #1;
        bus.fibonacci_standard = b;
        repeat (10) begin @(posedge clk); #1; lat++; end
        bus.begin_f_b = 1'b0;
        while (!bus.convert_done && lat < 60) begin @(posedge clk); #1; lat++; end
        checks++; if (lat != CONV_LAT) begin failures++; $display("FAIL ign_latency got=%0d exp=%0d", lat, CONV_LAT); end
        checks++; if (bus.binary_out !== ea) begin failures++; $display("FAIL ign_bin got=%0d exp=%0d", bus.binary_out, ea); end
        repeat (40) begin @(posedge clk); #1; if (bus.convert_done || bus.busy) extra++; end
        checks++; if (extra != 0) begin failures++; $display("FAIL ign_no_queue active_cycles got=%0d exp=0", extra); end
    endtask

    task automatic test_reset_midop();
        int lat, extra = 0; logic [15:0] b; logic nc, ov, bok, bdone;
        bus.fibonacci_standard = 32'h004A9114;
        bus.begin_f_b = 1'b1;
        @(posedge clk); #1;
        bus.begin_f_b = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b0 || bus.convert_done !== 1'b0 || bus.binary_out !== 16'h0 ||
                      bus.err_noncanonical !== 1'b0 || bus.err_overflow !== 1'b0) begin
            failures++; $display("FAIL midrst_outputs busy=%b done=%b bin=%h nc=%b ov=%b exp all 0",
                                 bus.busy, bus.convert_done, bus.binary_out, bus.err_noncanonical, bus.err_overflow);
        end
        rst = 1'b1;
        repeat (40) begin @(posedge clk); #1; if (bus.convert_done || bus.busy) extra++; end
        checks++; if (extra != 0) begin failures++; $display("FAIL midrst_no_done active_cycles got=%0d exp=0", extra); end
        convert(32'h5, lat, b, nc, ov, bok, bdone);
        checks++; if (lat != CONV_LAT || b !== 16'd4 || nc !== 1'b0 || ov !== 1'b0) begin
            failures++; $display("FAIL midrst_restart lat=%0d bin=%0d nc=%b ov=%b exp 33/4/0/0", lat, b, nc, ov);
        end
    endtask

    initial begin
        bus.begin_f_b = 1'b0;
        bus.fibonacci_standard = '0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_ignore_busy();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
